// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//  fetch_state_e : fetch FSM states
//  fetch_entry_t : one fetch-buffer entry (instruction word + its address + address+4)
//  is_aligned    : word-alignment check used on redirect targets
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_DEF    = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] EBREAK_INSTR_DEF = 32'h0010_0073;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } fetch_entry_t;

  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Bus between the fetch unit and its neighbours (instMem, execute, decode).
//  master : fetch unit side (drives PC and the decode-facing buffer outputs)
//  slave  : environment side (drives RD from instMem, redirect from execute,
//           readyIn from decode)
interface fetch_pc_unit_if;
  logic [31:0] RD;          // instruction word from instMem
  logic        PCSrc;       // redirect request
  logic [31:0] PCTarget;    // redirect target
  logic        readyIn;     // decode accepts buffered instruction
  logic [31:0] PC;          // fetch address to instMem.A
  logic [31:0] instrOut;    // buffered instruction
  logic [31:0] pcOut;       // address of instrOut
  logic [31:0] pcPlus4Out;  // pcOut + 4
  logic        validOut;    // buffer holds a valid instruction
  logic        halted;      // EBREAK fetched
  logic        fault;       // misaligned redirect seen

  modport master (
    input  RD, PCSrc, PCTarget, readyIn,
    output PC, instrOut, pcOut, pcPlus4Out, validOut, halted, fault
  );

  modport slave (
    output RD, PCSrc, PCTarget, readyIn,
    input  PC, instrOut, pcOut, pcPlus4Out, validOut, halted, fault
  );
endinterface

// File: rtl/fetch_pc_unit_buffer.sv
// One-entry fetch buffer between instMem and decode.
//  clk, rst  : clock, async active-high reset
//  load_i    : capture entry_i and mark valid
//  flush_i   : drop contents (valid cleared, instruction forced to NOP); wins over load
//  drain_i   : decode consumed the entry, clear valid only
//  entry_i   : {instr, pc, pc_plus4} to capture
//  entry_o   : current entry
//  valid_o   : entry is valid
module fetch_pc_unit_buffer
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         flush_i,
  input  logic         drain_i,
  input  fetch_entry_t entry_i,
  output fetch_entry_t entry_o,
  output logic         valid_o
);

  fetch_entry_t entry_q;
  logic         valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0};
      valid_q <= 1'b0;
    end else if (flush_i) begin
      // Address fields keep their last value; only the instruction is scrubbed.
      entry_q.instr <= NOP_INSTR;
      valid_q       <= 1'b0;
    end else if (load_i) begin
      entry_q <= entry_i;
      valid_q <= 1'b1;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign entry_o = entry_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end. Owns the PC, drives instMem address, captures
// the returned word into a one-entry buffer for decode, applies redirects,
// halts on EBREAK and stops on a misaligned redirect target.
//  clk   : system clock, rising edge
//  reset : asynchronous, active-high
//  bus   : fetch_pc_unit_if.master (RD/PCSrc/PCTarget/readyIn in,
//          PC/instrOut/pcOut/pcPlus4Out/validOut/halted/fault out)
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = NOP_INSTR_DEF,
  parameter logic [31:0] EBREAK_INSTR = EBREAK_INSTR_DEF
) (
  input  logic             clk,
  input  logic             reset,
  fetch_pc_unit_if.master  bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_plus4;

  logic         buf_load, buf_flush, buf_drain;
  logic         buf_valid;
  fetch_entry_t buf_entry;
  logic         accept;

  assign pc_plus4 = pc_q + 32'd4;  // wraps modulo 2^32
  assign accept   = !buf_valid || bus.readyIn;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (bus.PCSrc) begin
          if (!is_aligned(bus.PCTarget)) state_d = FAULT;
        end else if (accept && bus.RD == EBREAK_INSTR) begin
          state_d = HALTED;
        end
      end
      HALTED: state_d = HALTED;
      FAULT:  state_d = FAULT;
      default: state_d = BOOT;
    endcase
  end

  // Output / datapath control
  always_comb begin
    pc_d      = pc_q;
    buf_load  = 1'b0;
    buf_flush = 1'b0;
    buf_drain = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.PCSrc) begin
          // Redirect beats capture and readyIn; a bad target leaves PC alone.
          buf_flush = 1'b1;
          if (is_aligned(bus.PCTarget)) pc_d = bus.PCTarget;
        end else if (accept) begin
          buf_load = 1'b1;
          pc_d     = pc_plus4;
        end
      end
      HALTED: buf_drain = bus.readyIn;  // let the captured EBREAK reach decode
      default: ;
    endcase
  end

  fetch_pc_unit_buffer #(
    .NOP_INSTR (NOP_INSTR)
  ) u_buf (
    .clk     (clk),
    .rst     (reset),
    .load_i  (buf_load),
    .flush_i (buf_flush),
    .drain_i (buf_drain),
    .entry_i ('{instr: bus.RD, pc: pc_q, pc_plus4: pc_plus4}),
    .entry_o (buf_entry),
    .valid_o (buf_valid)
  );

  assign bus.PC         = pc_q;
  assign bus.instrOut   = buf_entry.instr;
  assign bus.pcOut      = buf_entry.pc;
  assign bus.pcPlus4Out = buf_entry.pc_plus4;
  assign bus.validOut   = buf_valid;
  assign bus.halted     = (state_q == HALTED);
  assign bus.fault      = (state_q == FAULT);

endmodule
